rr_mux_arbiter: RTL and testbench

// - Shares one W-bit output channel between N requesters.
// - The channel is an N:1 mux tree of 2:1 muxes (sel ? d1 : d0).
// - Round-robin arbitration with valid/ready handshakes on both sides.
// - One registered output slot, so out_data never glitches while held.
// - Sits between request sources (e.g. per-lane display/sound producers) and a single shared sink.

---
 rtl/rr_mux_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding one registered output slot through a 2:1 mux tree.
// Optional macro RR_MUX_ARB_LOCK_EN adds req_lock so a locked winner keeps top priority.
module rr_mux_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_valid,
   input  logic [N*W-1:0]   req_data,
`ifdef RR_MUX_ARB_LOCK_EN
   input  logic [N-1:0]     req_lock,
`endif
   output logic [N-1:0]     req_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   input  logic             out_ready,
   output logic [N-1:0]     grant
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned P  = 1 << IW;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IW-1:0]   ptr_q, ptr_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   int unsigned     cand;
   logic [IW-1:0]   cand_idx;
   logic [P*W-1:0]  mux_lvl;
   logic [IW-1:0]   sel_idx;
   logic [W-1:0]    mux_out;
   logic            slot_free;
   logic            accept;
   logic [N-1:0]    req_ready_c;

   // First valid requester searching from ptr, wrapping mod N
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand     = (32'(ptr_q) + off) % N;
         cand_idx = IW'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Binary tree of 2:1 muxes; each level consumes one bit of the winner index, LSB first
   always_comb begin
      mux_lvl            = '0;
      mux_lvl[N*W-1:0]   = req_data;
      sel_idx            = win_idx;
      for (int d = 0; d < int'(IW); d++) begin
         for (int k = 0; k < int'(P >> (d + 1)); k++) begin
            mux_lvl[k*W +: W] = sel_idx[0] ? mux_lvl[(2*k+1)*W +: W] : mux_lvl[(2*k)*W +: W];
         end
         sel_idx = sel_idx >> 1;
      end
      mux_out = mux_lvl[W-1:0];
   end

   assign slot_free = (state_q == EMPTY) || out_ready;
   assign accept    = slot_free && win_found;

   // Slot control: load on acceptance, drain when the sink takes data, hold under backpressure
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      req_ready_c = '0;
      if (accept) begin
         req_ready_c[win_idx] = 1'b1;
         state_d              = FULL;
         out_data_d           = mux_out;
         grant_d              = N'(1) << win_idx;
         ptr_d                = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
`ifdef RR_MUX_ARB_LOCK_EN
         if (req_lock[win_idx]) begin
            ptr_d = win_idx;
         end
`endif
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
         grant_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         grant_q    <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
      end
   end

   assign req_ready = {N{rst_n}} & req_ready_c;
   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N=4, W=8), with or without RR_MUX_ARB_LOCK_EN.
module tb_rr_mux_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_lock;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_ready;
   logic [N-1:0]   grant;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [3:0] rot_grant [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
   logic [7:0] rot_data  [4] = '{8'hB1, 8'hC2, 8'hD3, 8'hA0};

   rr_mux_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef RR_MUX_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant     (grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with random inputs
      rst_n     = 1'b0;
      req_valid = 4'($urandom);
      req_data  = 32'($urandom);
      out_ready = 1'($urandom);
      req_lock  = '0;
      repeat (3) step();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data",  32'(out_data),  32'h0);
      check("rst_grant", 32'(grant),     32'h0);
      check("rst_ready", 32'(req_ready), 32'h0);

      // All four valid, data = index: 0,1,2,3,0,1 back to back
      rst_n     = 1'b1;
      out_ready = 1'b1;
      req_valid = 4'hF;
      req_data  = {8'd3, 8'd2, 8'd1, 8'd0};
      #1;
      check("rr_ready0", 32'(req_ready), 32'h1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("rr_valid", 32'(out_valid), 32'h1);
         check("rr_data",  32'(out_data),  32'(k % 4));
         check("rr_grant", 32'(grant),     32'(1) << (k % 4));
      end

      // Drain to EMPTY
      req_valid = '0;
      step();
      check("drain_valid", 32'(out_valid), 32'h0);
      check("drain_grant", 32'(grant),     32'h0);

      // Single requester 2
      req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      req_valid = 4'b0100;
      #1;
      check("single_ready", 32'(req_ready), 32'h4);
      step();
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_data",  32'(out_data),  32'hA5);
      check("single_grant", 32'(grant),     32'h4);

      // Load 3C from requester 3 while the slot is draining (reload in same edge)
      req_data  = {8'h3C, 8'hA5, 8'h22, 8'h11};
      req_valid = 4'b1000;
      #1;
      check("bp_load_ready", 32'(req_ready), 32'h8);
      step();
      check("bp_load_data",  32'(out_data),  32'h3C);
      check("bp_load_grant", 32'(grant),     32'h8);

      // Backpressure for 5 cycles with every requester valid
      out_ready = 1'b0;
      req_valid = 4'hF;
      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      repeat (5) begin
         #1;
         check("bp_ready", 32'(req_ready), 32'h0);
         step();
         check("bp_valid", 32'(out_valid), 32'h1);
         check("bp_data",  32'(out_data),  32'h3C);
         check("bp_grant", 32'(grant),     32'h8);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'h1);
      step();
      check("bp_release_data",  32'(out_data),  32'hA0);
      check("bp_release_grant", 32'(grant),     32'h1);

      // Pointer now at 1: rotation, optionally preceded by a locked burst on requester 1
`ifdef RR_MUX_ARB_LOCK_EN
      req_lock = 4'b0010;
      repeat (3) begin
         step();
         check("lock_grant", 32'(grant),    32'h2);
         check("lock_data",  32'(out_data), 32'hB1);
      end
      req_lock = '0;
`endif
      for (int k = 0; k < 4; k++) begin
         step();
         check("rot_grant", 32'(grant),    32'(rot_grant[k]));
         check("rot_data",  32'(out_data), 32'(rot_data[k]));
      end

      // Reset mid-transfer with slot FULL from requester 3
      req_data  = {8'h77, 8'hC2, 8'hB1, 8'hA0};
      req_valid = 4'b1000;
      step();
      check("mid_grant", 32'(grant),    32'h8);
      check("mid_data",  32'(out_data), 32'h77);
      out_ready = 1'b0;
      req_valid = 4'hF;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_data",  32'(out_data),  32'h0);
      check("mid_rst_grant", 32'(grant),     32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'h1);
      step();
      check("post_rst_grant", 32'(grant),    32'h1);
      check("post_rst_data",  32'(out_data), 32'hA0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
